db_lcu_bank_ram: RTL and testbench
==================================

Name: db_lcu_bank_ram

Overview:
Parametrised true dual-port LCU pixel memory for the deblocking datapath, replacing the fixed 128-bit luma buffer. It adds byte-lane write masking, deterministic same-address collision handling with write-first bypass, an optional output register stage, and a post-reset clear engine. Both ports run on one clock. It serves as the luma/chroma working store between the deblocking filter and the LCU write-back logic.

Parameters:
DATA_WIDTH, 128, word width in bits; must be a multiple of BYTE_WIDTH
ADDR_WIDTH, 8, address bits; DEPTH = 1<<ADDR_WIDTH words
BYTE_WIDTH, 8, bits per write-mask lane; NB = DATA_WIDTH/BYTE_WIDTH lanes
OUT_REG, 0, 1 adds a second output pipeline register (read latency 2)
CLR_ON_RST, 1, 1 zero-fills the whole array after reset

Ports:
clk  in  1  clock for both ports
rst  in  1  synchronous reset, active-high
init_busy_o  out  1  high while the clear engine runs; port accesses are ignored
cena_i  in  1  port A chip enable, low active
rena_i  in  1  port A output enable, low active; high forces dataa_o to 0
wena_i  in  1  port A write enable, low active (high = read)
bwena_i  in  NB  port A byte-lane write enable, low active
addra_i  in  ADDR_WIDTH  port A address
dataa_i  in  DATA_WIDTH  port A write data
dataa_o  out  DATA_WIDTH  port A read data
cenb_i, renb_i, wenb_i, bwenb_i, addrb_i, datab_i, datab_o: port B equivalents
collision_o  out  1  one-cycle pulse: same-address write/write occurred in the previous cycle

Behaviour:
- Reset: while rst=1, the read registers and pipeline registers (both ports) are 0, collision_o=0, and the clear counter is 0. init_busy_o=1 if CLR_ON_RST=1, else 0.
- FSM (CLR_ON_RST=1): CLEAR -> READY. In CLEAR, one word of zeros is written per cycle at counter address 0..DEPTH-1. In the cycle after the write to DEPTH-1, the FSM moves to READY and init_busy_o falls. The clear therefore takes DEPTH cycles after rst deasserts.
- While busy, all port requests are dropped and the read registers hold 0.
- rst asserted mid-clear restarts the counter at 0. With CLR_ON_RST=0, the FSM is permanently READY and array contents are undefined after reset.
- Write (port X): active when !cenX && !wenX && READY. Lane i is written iff bwenX[i]=0. All-ones bwen writes nothing and is not a collision.
- Read (port X): active when !cenX && wenX && READY. The read register is loaded at the next edge. Latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1). The output holds its last value when no read is issued.
- dataa_o = rena_i ? 0 : pipeline output. This path is combinational on rena_i; the internal registers are unaffected by rena_i.
- Write/write, same address, same cycle: port A wins each lane both ports enable. Lanes enabled by only one port take that port's data. collision_o=1 on the next cycle, only if at least one lane overlaps.
- Read/write, same address, same cycle: the reading port returns write-first data. Lanes written that cycle (after A-priority merge) show new data; other lanes show old contents.
- Read/read, same address: both ports return identical data; no collision.
- Addresses wrap naturally at ADDR_WIDTH bits; no range check.
- With OUT_REG=1, a read issued on the last busy cycle is still dropped. Pipeline stage 2 loads stage 1 every cycle.

Test Plan:
- Clear: DATA_WIDTH=128, ADDR_WIDTH=8, CLR_ON_RST=1. Release rst -> init_busy_o stays high exactly 256 cycles. A port A read of addr 0xFF then returns 0 one cycle later.
- Byte mask: A writes 0x00..0F (lanes 0..15 = 0x00..0x0F) to addr 5 with bwena_i=16'h0000. Then A writes 0xFF.. with bwena_i=16'hFFFE. A read of addr 5 -> lane0=0xFF, lanes1..15 = 0x01..0x0F.
- W/W collision: same cycle, A writes all-0xAA with bwena_i=16'hFF00 and B writes all-0x55 with bwenb_i=16'hF000, both to addr 9. Result: collision_o=1 on the next cycle. A later read returns lanes0..7=0xAA, lanes8..11=0x55, lanes12..15 unchanged.
- Bypass: B reads addr 3 while A writes 0x1234...(full mask) to addr 3. datab_o equals the new word after 1 cycle, or after 2 cycles with OUT_REG=1.
- Output enable/hold: read addr 7 (value 0xC3..), then idle 4 cycles with rena_i toggling. dataa_o is 0 while rena_i=1 and 0xC3.. while rena_i=0.
- Reset mid-clear: assert rst at clear address 100 for 1 cycle. init_busy_o then stays high a further 256 cycles from deassertion, and requests issued during that time are ignored.

Source files
------------

// File: rtl/db_lcu_bank_ram_if.sv
// One access port of the LCU bank RAM. Enables are active low.
// The master drives the request; the slave (the RAM) returns read data.
interface db_lcu_bank_ram_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  cen_i;
    logic                  ren_i;
    logic                  wen_i;
    logic [NB-1:0]         bwen_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;

    modport master (
        output cen_i, ren_i, wen_i, bwen_i, addr_i, data_i,
        input  data_o
    );

    modport slave (
        input  cen_i, ren_i, wen_i, bwen_i, addr_i, data_i,
        output data_o
    );
endinterface

// File: rtl/db_lcu_bank_ram.sv
// True dual-port LCU pixel store: byte-lane masks, A-priority write merge, write-first bypass, post-reset zero fill.
// Read latency 1 (OUT_REG=0) or 2 (OUT_REG=1); no backpressure, requests are dropped while init_busy_o is high.
module db_lcu_bank_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter bit OUT_REG    = 1'b0,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy_o,
    db_lcu_bank_ram_if.slave port_a,
    db_lcu_bank_ram_if.slave port_b,
    output logic             collision_o
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [DATA_WIDTH-1:0] pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
    logic                  collision_q, collision_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic          ready, clr_we;
    logic          we_a, we_b, re_a, re_b, same_addr;
    logic [NB-1:0] lane_a, lane_b;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        if (state_q == ST_CLEAR) begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = ST_READY;
            end
        end
    end

    assign ready       = (state_q == ST_READY) && !rst;
    assign init_busy_o = rst ? CLR_ON_RST : (state_q == ST_CLEAR);

    assign we_a      = ready && !port_a.cen_i && !port_a.wen_i;
    assign we_b      = ready && !port_b.cen_i && !port_b.wen_i;
    assign re_a      = ready && !port_a.cen_i &&  port_a.wen_i;
    assign re_b      = ready && !port_b.cen_i &&  port_b.wen_i;
    assign lane_a    = {NB{we_a}} & ~port_a.bwen_i;
    assign lane_b    = {NB{we_b}} & ~port_b.bwen_i;
    assign same_addr = (port_a.addr_i == port_b.addr_i);

    // Port A is applied last so it owns any lane both ports write to the same word.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end
        for (int i = 0; i < NB; i++) begin
            if (lane_b[i]) begin
                mem[port_b.addr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_b.data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (lane_a[i]) begin
                mem[port_a.addr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= port_a.data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // A reading port can only collide with the other port's write, so bypass only that one.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (re_a) begin
            rd_a_d = mem[port_a.addr_i];
            for (int i = 0; i < NB; i++) begin
                if (lane_b[i] && same_addr) begin
                    rd_a_d[i*BYTE_WIDTH +: BYTE_WIDTH] = port_b.data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        if (re_b) begin
            rd_b_d = mem[port_b.addr_i];
            for (int i = 0; i < NB; i++) begin
                if (lane_a[i] && same_addr) begin
                    rd_b_d[i*BYTE_WIDTH +: BYTE_WIDTH] = port_a.data_i[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        pipe_a_d    = rd_a_q;
        pipe_b_d    = rd_b_q;
        collision_d = same_addr && (|(lane_a & lane_b));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLR_ON_RST ? ST_CLEAR : ST_READY;
            clr_cnt_q   <= '0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            pipe_a_q    <= '0;
            pipe_b_q    <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            pipe_a_q    <= pipe_a_d;
            pipe_b_q    <= pipe_b_d;
            collision_q <= collision_d;
        end
    end

    assign port_a.data_o = port_a.ren_i ? '0 : (OUT_REG ? pipe_a_q : rd_a_q);
    assign port_b.data_o = port_b.ren_i ? '0 : (OUT_REG ? pipe_b_q : rd_b_q);
    assign collision_o   = collision_q;
endmodule

// File: tb/tb_db_lcu_bank_ram.sv
// Bench for db_lcu_bank_ram: directed and random traffic scored against a lane-level memory model.
// Expected reads/collisions are queued at issue time and popped by a negedge monitor.
module tb_db_lcu_bank_ram;
    localparam int DW      = 128;
    localparam int AW      = 8;
    localparam int BW      = 8;
    localparam int NB      = DW / BW;
    localparam int DEPTH   = 1 << AW;
    localparam bit OUT_REG = 1'b0;
    localparam int LAT     = OUT_REG ? 2 : 1;

    typedef logic [DW-1:0] word_t;
    typedef struct {
        bit            cen;
        bit            ren;
        bit            wen;
        logic [NB-1:0] bwen;
        logic [AW-1:0] addr;
        word_t         data;
    } req_t;
    typedef struct {
        int    due;
        word_t val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic init_busy;
    logic collision;

    db_lcu_bank_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) pa ();
    db_lcu_bank_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) pb ();

    db_lcu_bank_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .OUT_REG(OUT_REG), .CLR_ON_RST(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_busy_o(init_busy),
        .port_a     (pa),
        .port_b     (pb),
        .collision_o(collision)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    word_t ref_mem [DEPTH];
    exp_t  qa[$];
    exp_t  qb[$];
    int    qc[$];
    bit    exp_busy = 1'b1;
    bit    in_rst   = 1'b1;
    int    k0       = 0;
    word_t held_a   = '0;
    word_t held_b   = '0;
    bit    mon_en   = 1'b0;
    int    vectors  = 0;
    int    miscompares = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic req_t idle(input bit ren = 1'b0);
        req_t r;
        r.cen = 1'b1; r.ren = ren; r.wen = 1'b1; r.bwen = '1; r.addr = '0; r.data = '0;
        return r;
    endfunction

    function automatic req_t wr(input logic [AW-1:0] ad, input word_t d, input logic [NB-1:0] m);
        req_t r;
        r = idle();
        r.cen = 1'b0; r.wen = 1'b0; r.addr = ad; r.data = d; r.bwen = m;
        return r;
    endfunction

    function automatic req_t rd(input logic [AW-1:0] ad);
        req_t r;
        r = idle();
        r.cen = 1'b0; r.addr = ad;
        return r;
    endfunction

    function automatic word_t rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int   sel;
        r.cen  = ($urandom_range(0, 3) == 0);
        r.ren  = ($urandom_range(0, 7) == 0);
        r.wen  = $urandom_range(0, 1);
        r.addr = AW'($urandom_range(0, 7));
        r.data = rnd_word();
        sel    = $urandom_range(0, 3);
        r.bwen = (sel == 0) ? '0 : (sel == 1) ? '1 : NB'($urandom);
        return r;
    endfunction

    // Reference: per lane, A wins where both ports write one word; reads see this cycle's writes.
    task automatic model_step(input req_t a, input req_t b);
        bit            wa, wb;
        logic [NB-1:0] ma, mb;
        wa = !a.cen && !a.wen;
        wb = !b.cen && !b.wen;
        ma = wa ? ~a.bwen : '0;
        mb = wb ? ~b.bwen : '0;
        if (a.addr == b.addr && (ma & mb) != '0) qc.push_back(cyc + 1);
        for (int i = 0; i < NB; i++) begin
            if (mb[i] && !(ma[i] && a.addr == b.addr))
                ref_mem[b.addr][i*BW +: BW] = b.data[i*BW +: BW];
            if (ma[i])
                ref_mem[a.addr][i*BW +: BW] = a.data[i*BW +: BW];
        end
        if (!a.cen && a.wen) qa.push_back(exp_t'{due: cyc + LAT, val: ref_mem[a.addr]});
        if (!b.cen && b.wen) qb.push_back(exp_t'{due: cyc + LAT, val: ref_mem[b.addr]});
    endtask

    task automatic drive(input req_t a, input req_t b, input bit r);
        rst = r;
        pa.cen_i = a.cen; pa.ren_i = a.ren; pa.wen_i = a.wen;
        pa.bwen_i = a.bwen; pa.addr_i = a.addr; pa.data_i = a.data;
        pb.cen_i = b.cen; pb.ren_i = b.ren; pb.wen_i = b.wen;
        pb.bwen_i = b.bwen; pb.addr_i = b.addr; pb.data_i = b.data;
    endtask

    task automatic apply(input req_t a, input req_t b, input bit r);
        drive(a, b, r);
        if (r) begin
            in_rst   = 1'b1;
            exp_busy = 1'b1;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            qa.push_back(exp_t'{due: cyc + 1, val: '0});
            qb.push_back(exp_t'{due: cyc + 1, val: '0});
        end else begin
            if (in_rst) begin
                in_rst = 1'b0;
                k0     = cyc;
            end
            exp_busy = (cyc - k0) < DEPTH;
            if (!exp_busy) model_step(a, b);
        end
        @(posedge clk);
        #1;
    endtask

    exp_t mon_e;
    bit   exp_c;
    always @(negedge clk) begin
        if (mon_en) begin
            while (qa.size() > 0 && qa[0].due <= cyc) begin
                mon_e  = qa.pop_front();
                held_a = mon_e.val;
            end
            while (qb.size() > 0 && qb[0].due <= cyc) begin
                mon_e  = qb.pop_front();
                held_b = mon_e.val;
            end
            exp_c = (qc.size() > 0 && qc[0] == cyc);
            if (exp_c) void'(qc.pop_front());
            check("dataa_o", pa.data_o, pa.ren_i ? '0 : held_a);
            check("datab_o", pb.data_o, pb.ren_i ? '0 : held_b);
            check("init_busy_o", word_t'(init_busy), word_t'(exp_busy));
            check("collision_o", word_t'(collision), word_t'(exp_c));
        end
    end

    word_t lanes_inc;
    initial begin
        drive(idle(), idle(), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        apply(idle(), idle(), 1'b1);

        // Clear window: every request here must be ignored.
        repeat (DEPTH) apply(rnd_req(), rnd_req(), 1'b0);
        apply(rd(8'hFF), idle(), 1'b0);
        for (int i = 0; i < 8; i++) apply(rd(AW'(i)), rd(AW'(7 - i)), 1'b0);

        for (int i = 0; i < NB; i++) lanes_inc[i*BW +: BW] = BW'(i);
        apply(wr(8'd5, lanes_inc, 16'h0000), idle(), 1'b0);
        apply(wr(8'd5, {NB{8'hFF}}, 16'hFFFE), idle(), 1'b0);
        apply(rd(8'd5), idle(), 1'b0);

        apply(wr(8'd9, rnd_word(), 16'h0000), idle(), 1'b0);
        apply(wr(8'd9, {NB{8'hAA}}, 16'hFF00), wr(8'd9, {NB{8'h55}}, 16'hF000), 1'b0);
        apply(rd(8'd9), idle(), 1'b0);
        apply(idle(), rd(8'd9), 1'b0);

        apply(wr(8'd3, 128'h123456789ABCDEF0_0FEDCBA987654321, 16'h0000), rd(8'd3), 1'b0);
        apply(idle(), idle(), 1'b0);

        apply(wr(8'd7, {NB{8'hC3}}, 16'h0000), idle(), 1'b0);
        apply(rd(8'd7), idle(), 1'b0);
        for (int i = 0; i < 4; i++) apply(idle(i[0] == 1'b0), idle(), 1'b0);

        apply(rd(8'd4), rd(8'd4), 1'b0);
        apply(wr(8'd4, rnd_word(), 16'hFFFF), wr(8'd4, rnd_word(), 16'hFFFF), 1'b0);

        repeat (400) apply(rnd_req(), rnd_req(), 1'b0);
        repeat (4) apply(idle(), idle(), 1'b0);

        // Restart the clear at counter address 100.
        apply(idle(), idle(), 1'b1);
        repeat (100) apply(rnd_req(), rnd_req(), 1'b0);
        apply(idle(), idle(), 1'b1);
        repeat (DEPTH) apply(rnd_req(), rnd_req(), 1'b0);
        for (int i = 0; i < 8; i++) apply(rd(AW'(i)), rd(AW'(i ^ 3)), 1'b0);
        apply(rd(8'hFF), rd(8'd100), 1'b0);
        repeat (4) apply(idle(), idle(), 1'b0);

        check("scoreboard_drained", word_t'(qa.size() + qb.size() + qc.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
